// File: rtl/k6502_seq_if.sv
// Sequencer bus: core-side controls in, ROM lookup and status out.
interface k6502_seq_if #(
  parameter int CNT_W = 16
);
  logic             rdy;
  logic [7:0]       data_in;
  logic             sync_next;
  logic             irq;
  logic             i_flag;
  logic [7:0]       ir;
  logic [5:0]       cycle;
  logic             sync;
  logic             jam;
  logic             int_taken;
  logic [CNT_W-1:0] icount;

  modport master (
    input  rdy, data_in, sync_next, irq, i_flag,
    output ir, cycle, sync, jam, int_taken, icount
  );

  modport slave (
    output rdy, data_in, sync_next, irq, i_flag,
    input  ir, cycle, sync, jam, int_taken, icount
  );
endinterface

// File: rtl/k6502_seq.sv
// k6502 instruction sequencer: opcode register, one-hot cycle counter, jam and retire count.
// Optional IRQ injection at fetch is enabled by defining K6502_SEQ_IRQ_EN.
//
// state   | meaning
// ST_RUN  | normal sequencing, cycle walks C_N..C_5 until SYNC NEXT
// ST_JAM  | sequence overran C_5; everything frozen until reset
module k6502_seq #(
  parameter int         CNT_W    = 16,
  parameter logic [7:0] RESET_OP = 8'h00
) (
  input logic          clk,
  input logic          reset,
  k6502_seq_if.master  bus
);

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_JAM = 1'b1
  } state_e;

  localparam logic [5:0] C_N = 6'b000000;
  localparam logic [5:0] C_0 = 6'b000001;
  localparam logic [5:0] C_5 = 6'b100000;

  state_e           state_q, state_d;
  logic [7:0]       ir_q, ir_d;
  logic [5:0]       cycle_q, cycle_d;
  logic             sync_q, sync_d;
  logic             int_taken_q, int_taken_d;
  logic [CNT_W-1:0] icount_q, icount_d;
  logic             advance;
  logic             irq_take;

`ifdef K6502_SEQ_IRQ_EN
  assign irq_take = bus.irq & ~bus.i_flag;
`else
  logic unused_irq;
  assign unused_irq = bus.irq ^ bus.i_flag;
  assign irq_take   = 1'b0;
`endif

  assign advance = bus.rdy && (state_q == ST_RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      ir_q        <= RESET_OP;
      cycle_q     <= C_N;
      sync_q      <= 1'b0;
      int_taken_q <= 1'b0;
      icount_q    <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      cycle_q     <= cycle_d;
      sync_q      <= sync_d;
      int_taken_q <= int_taken_d;
      icount_q    <= icount_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    cycle_d     = cycle_q;
    sync_d      = 1'b0;
    int_taken_d = 1'b0;
    icount_d    = icount_q;
    if (advance) begin
      if (bus.sync_next) begin
        ir_d        = irq_take ? 8'h00 : bus.data_in;
        int_taken_d = irq_take;
        cycle_d     = C_0;
        sync_d      = 1'b1;
        // the reset entry sequence is not a retired instruction
        if (cycle_q != C_N)
          icount_d = icount_q + CNT_W'(1);
      end else if (cycle_q == C_5) begin
        state_d = ST_JAM;
      end else if (cycle_q == C_N) begin
        cycle_d = C_0;
      end else begin
        cycle_d = cycle_q << 1;
      end
    end
  end

  assign bus.ir        = ir_q;
  assign bus.cycle     = cycle_q;
  assign bus.sync      = sync_q;
  assign bus.jam       = (state_q == ST_JAM);
  assign bus.int_taken = int_taken_q;
  assign bus.icount    = icount_q;

  a_cycle_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(cycle_q));

endmodule

// File: tb/tb_k6502_seq.sv
// Directed bench for k6502_seq: fetch/step, stall, jam, async reset, icount wrap, IRQ injection.
module tb_k6502_seq;
  localparam int CNT_W = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  k6502_seq_if #(.CNT_W(CNT_W)) bus ();

  k6502_seq #(.CNT_W(CNT_W), .RESET_OP(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sn, input logic [7:0] d);
    bus.sync_next = sn;
    bus.data_in   = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b1;
    bus.rdy       = 1'b1;
    bus.irq       = 1'b0;
    bus.i_flag    = 1'b0;
    drive(1'b1, 8'hEA);
    #12;
    check("rst_ir", bus.ir, 8'h00);
    check("rst_cycle", bus.cycle, 6'b000000);
    check("rst_sync", bus.sync, 1'b0);
    check("rst_jam", bus.jam, 1'b0);
    check("rst_int", bus.int_taken, 1'b0);
    check("rst_icount", bus.icount, 0);
    reset = 1'b0;

    // NOP: entry fetch, C_0 step, fetch at C_1
    tick();
    check("nop_ir", bus.ir, 8'hEA);
    check("nop_c0", bus.cycle, 6'b000001);
    check("nop_sync", bus.sync, 1'b1);
    check("nop_icount0", bus.icount, 0);
    drive(1'b0, 8'h11);
    tick();
    check("nop_c1", bus.cycle, 6'b000010);
    check("nop_sync_lo", bus.sync, 1'b0);
    drive(1'b1, 8'h6C);
    tick();
    check("jmp_ir", bus.ir, 8'h6C);
    check("jmp_c0", bus.cycle, 6'b000001);
    check("nop_icount1", bus.icount, 1);

    // JMP ind walks to C_4 then fetches
    drive(1'b0, 8'h22);
    tick(); check("jmp_c1", bus.cycle, 6'b000010);
    tick(); check("jmp_c2", bus.cycle, 6'b000100);
    tick(); check("jmp_c3", bus.cycle, 6'b001000);
    tick(); check("jmp_c4", bus.cycle, 6'b010000);
    check("jmp_ir_hold", bus.ir, 8'h6C);
    drive(1'b1, 8'hA9);
    tick();
    check("lda_ir", bus.ir, 8'hA9);
    check("lda_c0", bus.cycle, 6'b000001);
    check("jmp_icount", bus.icount, 2);
    check("jmp_nojam", bus.jam, 1'b0);

    // LDA imm with 3-cycle RDY stall at C_1
    drive(1'b0, 8'h33);
    tick();
    check("lda_c1", bus.cycle, 6'b000010);
    bus.rdy = 1'b0;
    drive(1'b1, 8'h44);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_ir", bus.ir, 8'hA9);
      check("stall_cycle", bus.cycle, 6'b000010);
      check("stall_sync", bus.sync, 1'b0);
      check("stall_icount", bus.icount, 2);
    end
    bus.rdy = 1'b1;
    drive(1'b1, 8'hFF);
    tick();
    check("ff_ir", bus.ir, 8'hFF);
    check("ff_c0", bus.cycle, 6'b000001);
    check("lda_icount", bus.icount, 3);

    // undefined opcode runs C_0..C_5 then jams
    drive(1'b0, 8'h55);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("ff_walk", bus.cycle, 6'b000001 << i);
      check("ff_walk_jam", bus.jam, 1'b0);
    end
    tick();
    check("ff_jam", bus.jam, 1'b1);
    check("ff_jam_cycle", bus.cycle, 6'b100000);
    check("ff_jam_ir", bus.ir, 8'hFF);
    drive(1'b1, 8'h4C);
    bus.irq = 1'b1;
    tick(); tick();
    check("jam_hold_jam", bus.jam, 1'b1);
    check("jam_hold_ir", bus.ir, 8'hFF);
    check("jam_hold_cycle", bus.cycle, 6'b100000);
    check("jam_hold_sync", bus.sync, 1'b0);
    check("jam_hold_icount", bus.icount, 3);
    check("jam_hold_int", bus.int_taken, 1'b0);
    bus.irq = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("jamrst_jam", bus.jam, 1'b0);
    check("jamrst_cycle", bus.cycle, 6'b000000);
    check("jamrst_ir", bus.ir, 8'h00);
    check("jamrst_icount", bus.icount, 0);
    @(negedge clk);
    reset = 1'b0;

    // JMP abs interrupted by async reset at C_2
    drive(1'b1, 8'h4C);
    tick();
    check("jabs_ir", bus.ir, 8'h4C);
    check("jabs_icount", bus.icount, 0);
    drive(1'b0, 8'h66);
    tick(); tick();
    check("jabs_c2", bus.cycle, 6'b000100);
    #3 reset = 1'b1;
    #1;
    check("arst_ir", bus.ir, 8'h00);
    check("arst_cycle", bus.cycle, 6'b000000);
    check("arst_icount", bus.icount, 0);
    @(negedge clk);
    reset = 1'b0;

    // sync_next at C_5 is a fetch, not an overrun
    drive(1'b1, 8'h01);
    tick();
    drive(1'b0, 8'h77);
    repeat (5) tick();
    check("c5_cycle", bus.cycle, 6'b100000);
    drive(1'b1, 8'hEA);
    tick();
    check("c5_fetch_jam", bus.jam, 1'b0);
    check("c5_fetch_ir", bus.ir, 8'hEA);
    check("c5_fetch_cycle", bus.cycle, 6'b000001);
    check("c5_fetch_icount", bus.icount, 1);

    // back-to-back fetches: icount wraps modulo 2^CNT_W
    repeat (14) tick();
    check("wrap_max", bus.icount, 15);
    tick();
    check("wrap_zero", bus.icount, 0);

    // IRQ at a fetch edge
    bus.irq    = 1'b1;
    bus.i_flag = 1'b0;
    drive(1'b1, 8'hA2);
    tick();
`ifdef K6502_SEQ_IRQ_EN
    check("irq_ir", bus.ir, 8'h00);
    check("irq_int", bus.int_taken, 1'b1);
`else
    check("irq_ir", bus.ir, 8'hA2);
    check("irq_int", bus.int_taken, 1'b0);
`endif
    check("irq_icount", bus.icount, 1);
    drive(1'b0, 8'hA2);
    tick();
    check("irq_int_pulse", bus.int_taken, 1'b0);
    check("irq_midinst_cycle", bus.cycle, 6'b000010);
    bus.i_flag = 1'b1;
    drive(1'b1, 8'hA2);
    tick();
    check("irqmask_ir", bus.ir, 8'hA2);
    check("irqmask_int", bus.int_taken, 1'b0);
    bus.irq = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
